lemmings_fsm_param: RTL
=======================

# lemmings_fsm_param

Parametrised Lemmings behaviour controller: the next generation of the single-lemming walk/fall/dig/splat FSM in the sequential-logic FSM exercises. It adds a configurable splat threshold, a visible saturating fall counter, an optional dig-depth limit, and a `revive` input that leaves the terminal SPLAT state without a full reset. It is a stand-alone Moore machine, and its exercise testbench drives it directly.

## Interface
- `SPLAT_CYCLES`, default 20: a landing after more than this many fall cycles splats.
- `FALL_W`, default 5: width of `fall_cnt`. Requires `SPLAT_CYCLES < 2**FALL_W - 1`; otherwise `$error` at elaboration.
- `DIG_MAX`, default 8: dig cycles before digging ends. Used only with `LEMMINGS_DIG_LIMIT_EN`. Range 1..2**`DIG_W`.
- `DIG_W`, default 4: width of the internal dig counter.
- `sys_clk`  in  1  rising-edge clock.
- `sys_rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `bump_left`  in  1  obstacle on left.
- `bump_right`  in  1  obstacle on right.
- `ground`  in  1  ground beneath lemming.
- `dig`  in  1  dig command.
- `revive`  in  1  leave SPLAT.
- `walk_left`  out  1  state is WALK_L.
- `walk_right`  out  1  state is WALK_R.
- `aaah`  out  1  state is FALL_L or FALL_R.
- `digging`  out  1  state is DIG_L or DIG_R.
- `splat`  out  1  state is SPLAT.
- `fall_cnt`  out  `FALL_W`  cycles spent in the current fall; saturating.

## Operation
- States: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. The registers are `cstate` and `nstate`, where `nstate` is combinational. Outputs are pure decodes of `cstate`, and exactly one output is high at a time.
- Transition priority, highest first, in WALK_x:
  - `!ground` goes to FALL_x.
  - `dig` goes to DIG_x.
  - Otherwise a bump reverses direction. WALK_L with `bump_left` goes to WALK_R. WALK_R with `bump_right` goes to WALK_L.
  - When both bumps are high, direction always reverses.
  - With none of the above, the state holds.
- FALL_x:
  - `ground` high with `fall_cnt > SPLAT_CYCLES` goes to SPLAT.
  - `ground` high otherwise goes to WALK_x, so direction is preserved.
  - `ground` low holds the state. Bumps and `dig` are ignored.
- DIG_x:
  - `!ground` goes to FALL_x; this has the highest priority.
  - Otherwise the state holds.
  - Bumps and `dig` are ignored.
- SPLAT:
  - `revive` goes to WALK_L.
  - All other inputs are ignored.
  - If `ground` is low after revive, the machine enters FALL_L on the following cycle.
- `fall_cnt`:
  - Cleared to 0 in every non-FALL state.
  - Counts +1 on each cycle `nstate` is FALL_x, so it equals 1 in the first FALL cycle.
  - Saturates at 2**`FALL_W`-1.
  - Holds its value while in SPLAT; it is cleared on revive.
- Dig counter (internal): 0 outside DIG. It increments each cycle in DIG.

## Timing
- Reset is sampled at the rising edge while `sys_rst_n`=0. The next state is WALK_L, and the counters are 0.
- Output values in reset: `walk_left`=1, and all other outputs 0, including `fall_cnt`=0.
- Reset asserted mid-fall or mid-dig wins over every transition and clears the counters on the same edge.
- Latency: an input sampled at edge N is reflected in the outputs after edge N, one cycle. There is no combinational input-to-output path.
- Landing after exactly `SPLAT_CYCLES` fall cycles goes to WALK. Landing after `SPLAT_CYCLES`+1 cycles goes to SPLAT.
- `ground` low and `dig` high together in WALK go to FALL, not DIG.

## Configuration
- Macro: `LEMMINGS_DIG_LIMIT_EN`.
- Defined: DIG_x with `ground` high goes to WALK_x once the dig counter reaches `DIG_MAX`-1. Digging therefore lasts exactly `DIG_MAX` cycles. The dig counter and `DIG_MAX`/`DIG_W` logic are compiled in.
- Undefined: DIG_x holds until `ground` drops, which is the classic behaviour. The dig counter is not synthesised.

## Test plan
- Reset, then `ground`=1 with no other inputs for 5 cycles: `walk_left`=1 throughout. Assert `sys_rst_n`=0 mid-run: the output is WALK_L on the next edge.
- In WALK_L, `bump_left` for 1 cycle: WALK_R. Then `bump_left`=`bump_right`=1 for 1 cycle: WALK_L. Then `ground`=0 and `dig`=1 together: `aaah`=1 and `fall_cnt`=1. Then `ground`=1: WALK_L.
- `ground`=0 for exactly 20 cycles, then 1: `fall_cnt` peaks at 20 and the state returns to WALK. Repeat with 21 cycles: `splat`=1 and the state holds for 10 cycles with the inputs toggling.
- From SPLAT, `revive`=1 with `ground`=1: WALK_L next cycle and `fall_cnt`=0. Repeat with `ground`=0: WALK_L, then FALL_L.
- `dig`=1 in WALK_R, then hold `ground`=1:
  - With the macro and `DIG_MAX`=8: DIG_R lasts 8 cycles, then WALK_R.
  - Without the macro: DIG_R persists for 30 cycles. Dropping `ground` then gives FALL_R, and landing gives WALK_R.
- Build with `FALL_W`=5 and `SPLAT_CYCLES`=31: elaboration fails.

Source files
------------

// File: rtl/lemmings_fsm_param.sv
// Lemmings walk/fall/dig/splat Moore controller with splat threshold, saturating fall counter and revive.
// Optional dig-depth limit compiled in with LEMMINGS_DIG_LIMIT_EN; outputs registered, one-cycle latency.
module lemmings_fsm_param #(
  parameter int SPLAT_CYCLES = 20,
  parameter int FALL_W       = 5,
  parameter int DIG_MAX      = 8,
  parameter int DIG_W        = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              bump_left,
  input  logic              bump_right,
  input  logic              ground,
  input  logic              dig,
  input  logic              revive,
  output logic              walk_left,
  output logic              walk_right,
  output logic              aaah,
  output logic              digging,
  output logic              splat,
  output logic [FALL_W-1:0] fall_cnt
);

  typedef enum logic [2:0] {
    WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT
  } state_t;

  state_t cstate;
  state_t nstate;
  logic   w_land_splat;
  logic   w_nfall;
  logic   w_dig_done;

  if (SPLAT_CYCLES >= (2 ** FALL_W) - 1) begin : g_bad_fall_cfg
    $error("lemmings_fsm_param: SPLAT_CYCLES must be below 2**FALL_W-1");
  end
  if (DIG_MAX < 1 || DIG_MAX > (2 ** DIG_W)) begin : g_bad_dig_cfg
    $error("lemmings_fsm_param: DIG_MAX must lie in 1..2**DIG_W");
  end

  assign w_land_splat = (fall_cnt > FALL_W'(SPLAT_CYCLES));
  assign w_nfall      = (nstate == FALL_L) || (nstate == FALL_R);

`ifdef LEMMINGS_DIG_LIMIT_EN
  logic [DIG_W-1:0] r_dig_cnt;
  logic             w_ndig_cont;

  // The counter restarts from zero on the first DIG cycle, so the exit compare lands on cycle DIG_MAX.
  assign w_ndig_cont = ((nstate == DIG_L) || (nstate == DIG_R)) &&
                       ((cstate == DIG_L) || (cstate == DIG_R));
  assign w_dig_done  = (r_dig_cnt == DIG_W'(DIG_MAX - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_dig_cnt <= '0;
    end else if (w_ndig_cont) begin
      r_dig_cnt <= r_dig_cnt + 1'b1;
    end else begin
      r_dig_cnt <= '0;
    end
  end
`else
  assign w_dig_done = 1'b0;
`endif

  always_comb begin
    nstate = cstate;
    case (cstate)
      WALK_L: begin
        if (!ground)        nstate = FALL_L;
        else if (dig)       nstate = DIG_L;
        else if (bump_left) nstate = WALK_R;
      end
      WALK_R: begin
        if (!ground)         nstate = FALL_R;
        else if (dig)        nstate = DIG_R;
        else if (bump_right) nstate = WALK_L;
      end
      FALL_L: if (ground) nstate = w_land_splat ? SPLAT : WALK_L;
      FALL_R: if (ground) nstate = w_land_splat ? SPLAT : WALK_R;
      DIG_L: begin
        if (!ground)         nstate = FALL_L;
        else if (w_dig_done) nstate = WALK_L;
      end
      DIG_R: begin
        if (!ground)         nstate = FALL_R;
        else if (w_dig_done) nstate = WALK_R;
      end
      SPLAT:   if (revive) nstate = WALK_L;
      default: nstate = WALK_L;
    endcase
  end

  // Outputs are decoded from nstate here so they register together with cstate.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cstate     <= WALK_L;
      fall_cnt   <= '0;
      walk_left  <= 1'b1;
      walk_right <= 1'b0;
      aaah       <= 1'b0;
      digging    <= 1'b0;
      splat      <= 1'b0;
    end else begin
      cstate <= nstate;
      if (w_nfall) begin
        if (fall_cnt != '1) fall_cnt <= fall_cnt + 1'b1;
      end else if (nstate != SPLAT) begin
        fall_cnt <= '0;
      end
      walk_left  <= (nstate == WALK_L);
      walk_right <= (nstate == WALK_R);
      aaah       <= w_nfall;
      digging    <= (nstate == DIG_L) || (nstate == DIG_R);
      splat      <= (nstate == SPLAT);
    end
  end

endmodule
